// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//
// Serial-to-parallel receiver for the 16-bit serial link. Bits arrive MSB
// first, each qualified by ser_data_val_i. Gaps between bits are allowed.
// Bits are packed into a word of 1 to 16 bits. A word ends when the sender
// flags its final bit with ser_last_i, or when the 16th bit arrives. Each
// completed word is presented for exactly one cycle with its bit count.
// The link has no backpressure, so the consumer must take the word on the
// pulse.
//
// Ports
//   clk_i            in   1   clock, rising edge
//   rst_n_i          in   1   asynchronous active-low reset
//   ser_data_i       in   1   serial data bit, MSB of word first
//   ser_data_val_i   in   1   ser_data_i valid this cycle
//   ser_last_i       in   1   final bit of word (only when ser_data_val_i=1)
//   deser_data_o     out  16  assembled word, first bit at [15], low bits 0
//   deser_mod_o      out  4   bits in word, 0 encodes 16
//   deser_data_val_o out  1   one-cycle pulse qualifying data/mod
//   busy_o           out  1   a partial word (1..15 bits) is being held
// -----------------------------------------------------------------------------
module deserializer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ser_data_i,
    input  logic        ser_data_val_i,
    input  logic        ser_last_i,
    output logic [15:0] deser_data_o,
    output logic [3:0]  deser_mod_o,
    output logic        deser_data_val_o,
    output logic        busy_o
);

    // Assembly state: the partially filled word and the number of bits in it.
    // The receive state is implicit in the count: zero means idle, and a
    // nonzero count means a word is being collected.
    logic [15:0] sh_q,    sh_d;
    logic [4:0]  cnt_q,   cnt_d;

    // Registered outputs.
    logic [15:0] data_q,  data_d;
    logic [3:0]  mod_q,   mod_d;
    logic        val_q,   val_d;
    logic        busy_q,  busy_d;

    // Helper terms for the bit being accepted this cycle.
    logic [4:0]  cnt_inc;
    logic [3:0]  bit_idx;
    logic [15:0] sh_fill;
    logic [15:0] keep_mask;
    logic        word_done;

    // Next-state logic.
    // The count never rests at 16 because the 16th bit always completes the
    // word. Its low four bits are therefore enough to address the slot. The
    // first bit goes to [15] and later bits fill downward. keep_mask keeps
    // only the filled top cnt_inc bits. Shifting all ones right by 16 gives
    // zero, so a full word keeps every bit.
    always_comb begin
        cnt_inc   = cnt_q + 5'd1;
        bit_idx   = 4'd15 - cnt_q[3:0];
        sh_fill   = sh_q;
        sh_fill[bit_idx] = ser_data_i;
        word_done = ser_last_i || (cnt_inc == 5'd16);
        keep_mask = ~(16'hFFFF >> cnt_inc);

        sh_d   = sh_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        mod_d  = mod_q;
        val_d  = 1'b0;
        busy_d = busy_q;

        if (ser_data_val_i) begin
            if (word_done) begin
                data_d = sh_fill & keep_mask;
                mod_d  = cnt_inc[3:0];
                val_d  = 1'b1;
                sh_d   = 16'h0000;
                cnt_d  = 5'd0;
                busy_d = 1'b0;
            end else begin
                sh_d   = sh_fill;
                cnt_d  = cnt_inc;
                busy_d = 1'b1;
            end
        end
    end

    // State and output registers.
    // Reset throws away any partial word without emitting it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q   <= 16'h0000;
            cnt_q  <= 5'd0;
            data_q <= 16'h0000;
            mod_q  <= 4'd0;
            val_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            mod_q  <= mod_d;
            val_q  <= val_d;
            busy_q <= busy_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_mod_o      = mod_q;
    assign deser_data_val_o = val_q;
    assign busy_o           = busy_q;

endmodule
